// File: rtl/id_ctrl_blk_seq.sv
// id_ctrl_blk_seq: registered ID-stage control unit for the ARM-subset pipeline.
// Decodes opcode/mode/S into the EXE command and the MEM/WB/branch/S enables.
// For LDM/STM it issues one memory micro-op per register-list bit, lowest bit
// first, with a byte offset that steps by 4. The unit also honours hold and flush.
module id_ctrl_blk_seq #(
  parameter int REG_CNT = 16,
  parameter int RIDX_W  = 4,
  parameter int OFF_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               ready,
  input  logic               s_in,
  input  logic [1:0]         mode,
  input  logic [3:0]         opcode,
  input  logic               multi,
  input  logic [REG_CNT-1:0] reg_list,
  input  logic               hold,
  input  logic               flush,
  output logic               out_valid,
  output logic [3:0]         exe_cmd,
  output logic               mem_w_en,
  output logic               mem_r_en,
  output logic               wb_en,
  output logic               branch,
  output logic               s_out,
  output logic [RIDX_W-1:0]  uop_rd,
  output logic [OFF_W-1:0]   uop_off
);

  localparam int CNT_W = $clog2(REG_CNT + 1);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t               state_q, state_d;
  logic [REG_CNT-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ld_q, ld_d;
  logic                 vld_q, vld_d;
  logic [3:0]           cmd_q, cmd_d;
  logic                 mw_q, mw_d;
  logic                 mr_q, mr_d;
  logic                 wb_q, wb_d;
  logic                 br_q, br_d;
  logic                 s_q, s_d;
  logic [RIDX_W-1:0]    rd_q, rd_d;
  logic [OFF_W-1:0]     off_q, off_d;

  // ALU command decode; every mode uses the same table
  function automatic logic [3:0] exe_cmd_f(input logic [3:0] op);
    case (op)
      4'b1101: exe_cmd_f = 4'b0001;
      4'b1111: exe_cmd_f = 4'b1001;
      4'b0100: exe_cmd_f = 4'b0010;
      4'b0101: exe_cmd_f = 4'b0011;
      4'b0010: exe_cmd_f = 4'b0100;
      4'b0110: exe_cmd_f = 4'b0101;
      4'b0000: exe_cmd_f = 4'b0110;
      4'b1100: exe_cmd_f = 4'b0111;
      4'b0001: exe_cmd_f = 4'b1000;
      4'b1010: exe_cmd_f = 4'b0100;
      4'b1000: exe_cmd_f = 4'b0110;
      default: exe_cmd_f = 4'b0001;
    endcase
  endfunction

  // Index of the lowest set bit; 0 for an empty mask
  function automatic logic [RIDX_W-1:0] lowest_f(input logic [REG_CNT-1:0] m);
    lowest_f = '0;
    for (int i = REG_CNT - 1; i >= 0; i--) begin
      if (m[i]) lowest_f = RIDX_W'(i);
    end
  endfunction

  assign ready     = ~hold & (state_q == IDLE);
  assign out_valid = vld_q;
  assign exe_cmd   = cmd_q;
  assign mem_w_en  = mw_q;
  assign mem_r_en  = mr_q;
  assign wb_en     = wb_q;
  assign branch    = br_q;
  assign s_out     = s_q;
  assign uop_rd    = rd_q;
  assign uop_off   = off_q;

  // Next-state and next-output selection: flush > hold > SEQ issue > accept
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    vld_d   = 1'b0;
    cmd_d   = '0;
    mw_d    = 1'b0;
    mr_d    = 1'b0;
    wb_d    = 1'b0;
    br_d    = 1'b0;
    s_d     = 1'b0;
    rd_d    = '0;
    off_d   = '0;
    if (flush) begin
      state_d = IDLE;
      mask_d  = '0;
      cnt_d   = '0;
    end else if (hold) begin
      vld_d = vld_q;
      cmd_d = cmd_q;
      mw_d  = mw_q;
      mr_d  = mr_q;
      wb_d  = wb_q;
      br_d  = br_q;
      s_d   = s_q;
      rd_d  = rd_q;
      off_d = off_q;
    end else if (state_q == SEQ) begin
      vld_d  = 1'b1;
      cmd_d  = 4'b0010;
      mr_d   = ld_q;
      wb_d   = ld_q;
      mw_d   = ~ld_q;
      rd_d   = lowest_f(mask_q);
      off_d  = OFF_W'({cnt_q, 2'b00});
      mask_d = mask_q & (mask_q - REG_CNT'(1));
      cnt_d  = cnt_q + CNT_W'(1);
      if (mask_d == '0) state_d = IDLE;
    end else if (in_valid) begin
      if (mode == 2'b01 && multi) begin
        if (reg_list != '0) begin
          vld_d  = 1'b1;
          cmd_d  = 4'b0010;
          mr_d   = s_in;
          wb_d   = s_in;
          mw_d   = ~s_in;
          rd_d   = lowest_f(reg_list);
          mask_d = reg_list & (reg_list - REG_CNT'(1));
          cnt_d  = CNT_W'(1);
          ld_d   = s_in;
          if (mask_d != '0) state_d = SEQ;
        end
      end else begin
        vld_d = 1'b1;
        cmd_d = exe_cmd_f(opcode);
        case (mode)
          2'b00: begin
            s_d  = s_in;
            wb_d = ~(opcode == 4'b1010 || opcode == 4'b1000);
          end
          2'b01: begin
            wb_d = s_in;
            mr_d = s_in;
            mw_d = ~s_in;
          end
          2'b10:   br_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      vld_q   <= 1'b0;
      cmd_q   <= '0;
      mw_q    <= 1'b0;
      mr_q    <= 1'b0;
      wb_q    <= 1'b0;
      br_q    <= 1'b0;
      s_q     <= 1'b0;
      rd_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      vld_q   <= vld_d;
      cmd_q   <= cmd_d;
      mw_q    <= mw_d;
      mr_q    <= mr_d;
      wb_q    <= wb_d;
      br_q    <= br_d;
      s_q     <= s_d;
      rd_q    <= rd_d;
      off_q   <= off_d;
    end
  end

endmodule

// File: tb/tb_id_ctrl_blk_seq.sv
// Bench for id_ctrl_blk_seq: directed instruction sequences with literal
// expectations, plus a queue-based reference model compared every cycle.
module tb_id_ctrl_blk_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, s_in, multi, hold, flush;
  logic [1:0]  mode;
  logic [3:0]  opcode;
  logic [15:0] reg_list;
  logic        ready, out_valid, mem_w_en, mem_r_en, wb_en, branch, s_out;
  logic [3:0]  exe_cmd;
  logic [3:0]  uop_rd;
  logic [5:0]  uop_off;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ctrl_blk_seq #(.REG_CNT(16), .RIDX_W(4), .OFF_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ready(ready), .s_in(s_in),
    .mode(mode), .opcode(opcode), .multi(multi), .reg_list(reg_list),
    .hold(hold), .flush(flush), .out_valid(out_valid), .exe_cmd(exe_cmd),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .wb_en(wb_en), .branch(branch),
    .s_out(s_out), .uop_rd(uop_rd), .uop_off(uop_off)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic       vld;
    logic [3:0] cmd;
    logic       mw, mr, wb, br, s;
    logic [3:0] rd;
    logic [5:0] off;
  } op_t;

  op_t  pend[$];
  op_t  cur;
  logic data_known;
  logic live = 1'b0;
  logic [3:0] cmd_lut [16];

  initial begin
    for (int i = 0; i < 16; i++) cmd_lut[i] = 4'b0001;
    cmd_lut[4'b1111] = 4'b1001; cmd_lut[4'b0100] = 4'b0010;
    cmd_lut[4'b0101] = 4'b0011; cmd_lut[4'b0010] = 4'b0100;
    cmd_lut[4'b0110] = 4'b0101; cmd_lut[4'b0000] = 4'b0110;
    cmd_lut[4'b1100] = 4'b0111; cmd_lut[4'b0001] = 4'b1000;
    cmd_lut[4'b1010] = 4'b0100; cmd_lut[4'b1000] = 4'b0110;
  end

  function automatic op_t zero_op();
    op_t z;
    z = '{vld: 1'b0, cmd: 4'd0, mw: 1'b0, mr: 1'b0, wb: 1'b0, br: 1'b0, s: 1'b0, rd: 4'd0, off: 6'd0};
    return z;
  endfunction

  // Compare against the model, then advance the model with the inputs the next edge will see
  always @(negedge clk) begin
    op_t n;
    int  k;
    if (live) begin
      chk("m_valid", out_valid, cur.vld);
      chk("m_mem_w", mem_w_en, cur.mw);
      chk("m_mem_r", mem_r_en, cur.mr);
      chk("m_wb", wb_en, cur.wb);
      chk("m_branch", branch, cur.br);
      chk("m_s_out", s_out, cur.s);
      chk("m_ready", ready, !hold && pend.size() == 0);
      if (cur.vld || data_known) begin
        chk("m_exe_cmd", exe_cmd, cur.cmd);
        chk("m_uop_rd", uop_rd, cur.rd);
        chk("m_uop_off", uop_off, cur.off);
      end
    end
    if (rst) begin
      pend.delete();
      cur = zero_op();
      data_known = 1'b1;
      live = 1'b1;
    end else if (flush) begin
      pend.delete();
      cur = zero_op();
      data_known = 1'b0;
    end else if (hold) begin
      // outputs repeat
    end else if (pend.size() != 0) begin
      cur = pend.pop_front();
      data_known = 1'b1;
    end else if (in_valid) begin
      data_known = 1'b1;
      if (mode == 2'b01 && multi) begin
        k = 0;
        for (int b = 0; b < 16; b++) begin
          if (reg_list[b]) begin
            n = zero_op();
            n.vld = 1'b1; n.cmd = 4'b0010;
            n.mr = s_in; n.wb = s_in; n.mw = !s_in;
            n.rd = 4'(b); n.off = 6'(4 * k);
            pend.push_back(n);
            k++;
          end
        end
        cur = (pend.size() != 0) ? pend.pop_front() : zero_op();
      end else begin
        n = zero_op();
        n.vld = 1'b1;
        n.cmd = cmd_lut[opcode];
        if (mode == 2'b00) begin
          n.s  = s_in;
          n.wb = !(opcode == 4'b1010 || opcode == 4'b1000);
        end else if (mode == 2'b01) begin
          n.wb = s_in; n.mr = s_in; n.mw = !s_in;
        end else if (mode == 2'b10) begin
          n.br = 1'b1;
        end
        cur = n;
      end
    end else begin
      cur = zero_op();
      data_known = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [3:0] op, input logic s,
                       input logic mu, input logic [15:0] rl);
    in_valid = 1'b1; mode = m; opcode = op; s_in = s; multi = mu; reg_list = rl;
  endtask

  task automatic idle();
    in_valid = 1'b0; mode = 2'b11; opcode = 4'd0; s_in = 1'b0; multi = 1'b0; reg_list = 16'd0;
  endtask

  task automatic uop(input string name, input logic [3:0] rd, input logic [5:0] off, input logic rdy);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_rd"}, uop_rd, rd);
    chk({name, "_off"}, uop_off, off);
    chk({name, "_ready"}, ready, rdy);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    idle();
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_exe_cmd", exe_cmd, 4'd0);
    chk("rst_ready", ready, 1'b1);

    // ADD then CMP
    cyc();
    drive(2'b00, 4'b0100, 1'b1, 1'b0, 16'd0);
    cyc();
    drive(2'b00, 4'b1010, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    chk("add_valid", out_valid, 1'b1);
    chk("add_cmd", exe_cmd, 4'b0010);
    chk("add_wb", wb_en, 1'b1);
    chk("add_s", s_out, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("cmp_cmd", exe_cmd, 4'b0100);
    chk("cmp_wb", wb_en, 1'b0);
    cyc();
    @(negedge clk);
    chk("idle_valid", out_valid, 1'b0);

    // LDM 0x0085 with a MOV waiting that must not be taken during SEQ
    cyc();
    drive(2'b01, 4'd0, 1'b1, 1'b1, 16'h0085);
    cyc();
    drive(2'b00, 4'b1101, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    uop("ldm0", 4'd0, 6'd0, 1'b0);
    chk("ldm_mem_r", mem_r_en, 1'b1);
    chk("ldm_wb", wb_en, 1'b1);
    chk("ldm_cmd", exe_cmd, 4'b0010);
    cyc(); @(negedge clk); uop("ldm1", 4'd2, 6'd4, 1'b0);
    cyc(); @(negedge clk); uop("ldm2", 4'd7, 6'd8, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("mov_after_ldm_valid", out_valid, 1'b1);
    chk("mov_after_ldm_cmd", exe_cmd, 4'b0001);

    // STM 0x8000
    cyc();
    drive(2'b01, 4'd0, 1'b0, 1'b1, 16'h8000);
    cyc(); idle();
    @(negedge clk);
    uop("stm", 4'd15, 6'd0, 1'b1);
    chk("stm_mem_w", mem_w_en, 1'b1);
    chk("stm_mem_r", mem_r_en, 1'b0);

    // Hold for two cycles after the first micro-op of 0x000F
    cyc();
    drive(2'b01, 4'd0, 1'b1, 1'b1, 16'h000F);
    cyc(); idle(); hold = 1'b1;
    @(negedge clk); uop("hold_a", 4'd0, 6'd0, 1'b0);
    cyc(); @(negedge clk); uop("hold_b", 4'd0, 6'd0, 1'b0);
    cyc(); hold = 1'b0;
    @(negedge clk); uop("hold_c", 4'd0, 6'd0, 1'b0);
    cyc(); @(negedge clk); uop("hold_r1", 4'd1, 6'd4, 1'b0);
    cyc(); @(negedge clk); uop("hold_r2", 4'd2, 6'd8, 1'b0);
    cyc(); @(negedge clk); uop("hold_r3", 4'd3, 6'd12, 1'b1);

    // Flush after the second micro-op of 0x00FF, MOV follows at once
    cyc();
    drive(2'b01, 4'd0, 1'b1, 1'b1, 16'h00FF);
    cyc(); idle();
    @(negedge clk); uop("fl0", 4'd0, 6'd0, 1'b0);
    cyc(); flush = 1'b1;
    @(negedge clk); uop("fl1", 4'd1, 6'd4, 1'b0);
    cyc(); flush = 1'b0;
    drive(2'b00, 4'b1101, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_wb", wb_en, 1'b0);
    chk("flush_ready", ready, 1'b1);
    cyc(); idle();
    @(negedge clk);
    chk("flush_mov_valid", out_valid, 1'b1);
    chk("flush_mov_cmd", exe_cmd, 4'b0001);

    // Flush while held
    cyc();
    drive(2'b01, 4'd0, 1'b0, 1'b1, 16'h0007);
    cyc(); idle(); hold = 1'b1; flush = 1'b1;
    cyc(); hold = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("holdflush_valid", out_valid, 1'b0);
    chk("holdflush_mem_w", mem_w_en, 1'b0);
    chk("holdflush_ready", ready, 1'b1);

    // Reset during SEQ, then empty-list LDM, then branch
    cyc();
    drive(2'b01, 4'd0, 1'b0, 1'b1, 16'h000F);
    cyc(); idle();
    @(negedge clk); uop("rs0", 4'd0, 6'd0, 1'b0);
    cyc(); rst = 1'b1;
    @(negedge clk); uop("rs1", 4'd1, 6'd4, 1'b0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("rstseq_valid", out_valid, 1'b0);
    chk("rstseq_mem_w", mem_w_en, 1'b0);
    chk("rstseq_rd", uop_rd, 4'd0);
    chk("rstseq_off", uop_off, 6'd0);
    chk("rstseq_cmd", exe_cmd, 4'd0);
    chk("rstseq_ready", ready, 1'b1);
    cyc();
    drive(2'b01, 4'd0, 1'b1, 1'b1, 16'h0000);
    cyc(); idle();
    @(negedge clk);
    chk("empty_valid", out_valid, 1'b0);
    chk("empty_ready", ready, 1'b1);
    cyc();
    drive(2'b10, 4'd0, 1'b0, 1'b0, 16'd0);
    cyc(); idle();
    @(negedge clk);
    chk("br_valid", out_valid, 1'b1);
    chk("br_branch", branch, 1'b1);
    chk("br_wb", wb_en, 1'b0);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
